// File: rtl/rtlmem_pkg.sv
// rtlmem_pkg: shared latency bounds, collision policy and clear-FSM states
package rtlmem_pkg;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;
  localparam bit COLL_A_WINS = 1'b1;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_st_e;
endpackage

// File: rtl/rtlmem_2rwpx_if.sv
// rtlmem_2rwpx_if: clear handshake plus both memory ports
interface rtlmem_2rwpx_if #(
  parameter int G_ADDR = 10,
  parameter int G_WIDTH = 16
);
  logic clren, clrrdy;
  logic [G_ADDR-1:0] memad_a, memad_b;
  logic memwe_a, memwe_b;
  logic [G_WIDTH-1:0] memdi_a, memdi_b;
  logic memre_a, memre_b;
  logic [G_WIDTH-1:0] memdo_a, memdo_b;
  logic memvld_a, memvld_b, coll_err;
  modport master (
    output clren, memad_a, memad_b, memwe_a, memwe_b, memdi_a, memdi_b, memre_a, memre_b,
    input clrrdy, memdo_a, memdo_b, memvld_a, memvld_b, coll_err
  );
  modport slave (
    input clren, memad_a, memad_b, memwe_a, memwe_b, memdi_a, memdi_b, memre_a, memre_b,
    output clrrdy, memdo_a, memdo_b, memvld_a, memvld_b, coll_err
  );
endinterface

// File: rtl/rtlmem_core.sv
// rtlmem_core: true-dual-port array, one registered read stage, write-first across ports
module rtlmem_core import rtlmem_pkg::*; #(
  parameter int G_ADDR = 10,
  parameter int G_WIDTH = 16,
  parameter int G_DEPTH = 2**G_ADDR
) (
  input  logic clk,
  input  logic we_a_i,
  input  logic [G_ADDR-1:0] ad_a_i,
  input  logic [G_WIDTH-1:0] di_a_i,
  input  logic we_b_i,
  input  logic [G_ADDR-1:0] ad_b_i,
  input  logic [G_WIDTH-1:0] di_b_i,
  output logic [G_WIDTH-1:0] do_a_o,
  output logic [G_WIDTH-1:0] do_b_o
);
  logic [G_WIDTH-1:0] mem_q [G_DEPTH];
  logic [G_WIDTH-1:0] rd_a_d, rd_b_d, rd_a_q, rd_b_q;
  logic same_ad;
  assign same_ad = ad_a_i == ad_b_i;
  // a port only reads while not writing, so the only bypass needed is from the other port
  assign rd_a_d = (we_b_i && same_ad) ? di_b_i : mem_q[ad_a_i];
  assign rd_b_d = (we_a_i && same_ad) ? di_a_i : mem_q[ad_b_i];
  assign do_a_o = rd_a_q;
  assign do_b_o = rd_b_q;
  // array writes with port A taking a same-address collision, plus the read register
  always_ff @(posedge clk) begin
    if (we_a_i) mem_q[ad_a_i] <= di_a_i;
    if (we_b_i && !(COLL_A_WINS && we_a_i && same_ad)) mem_q[ad_b_i] <= di_b_i;
    rd_a_q <= rd_a_d;
    rd_b_q <= rd_b_d;
  end
endmodule

// File: rtl/rtlmem_2rwpx.sv
// rtlmem_2rwpx: two shared R/W ports with configurable read latency and a clear engine
module rtlmem_2rwpx import rtlmem_pkg::*; #(
  parameter int G_ADDR = 10,
  parameter int G_WIDTH = 16,
  parameter int G_DEPTH = 2**G_ADDR,
  parameter int G_LATENCY = 2,
  parameter logic [G_WIDTH-1:0] G_RST_VAL = '0
) (
  input logic clk,
  input logic rst,
  rtlmem_2rwpx_if.slave bus
);
  if (G_LATENCY < LAT_MIN || G_LATENCY > LAT_MAX) begin : g_bad_latency
    $error("G_LATENCY outside LAT_MIN..LAT_MAX");
  end
  clr_st_e state_q, state_d;
  logic [G_ADDR-1:0] cnt_q, cnt_d;
  logic busy, we_a, we_b, coll_q;
  logic [1:0] rd;
  logic [1:0][G_WIDTH-1:0] core_do, pipe_do;
  logic [1:0][G_LATENCY-1:0] vld_q;
  assign busy = state_q == CLEAR;
  assign we_a = bus.memwe_a && !busy;
  assign we_b = bus.memwe_b && !busy;
  assign rd = busy ? 2'b00 : {bus.memre_b && !bus.memwe_b, bus.memre_a && !bus.memwe_a};
  // clear engine walks every address once, then drops back to IDLE
  always_comb begin
    cnt_d = busy ? cnt_q + 1'b1 : '0;
    state_d = busy ? ((cnt_q == G_ADDR'(G_DEPTH - 1)) ? IDLE : CLEAR) : (bus.clren ? CLEAR : IDLE);
  end
  // control state, valid pipeline and collision flag; reset flushes every in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      vld_q <= '0;
      coll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      for (int p = 0; p < 2; p++) vld_q[p] <= G_LATENCY'({vld_q[p], rd[p]});
      coll_q <= we_a && we_b && bus.memad_a == bus.memad_b;
    end
  end
  rtlmem_core #(.G_ADDR(G_ADDR), .G_WIDTH(G_WIDTH), .G_DEPTH(G_DEPTH)) u_core (
    .clk(clk),
    .we_a_i(we_a || busy),
    .ad_a_i(busy ? cnt_q : bus.memad_a),
    .di_a_i(busy ? G_RST_VAL : bus.memdi_a),
    .we_b_i(we_b),
    .ad_b_i(bus.memad_b),
    .di_b_i(bus.memdi_b),
    .do_a_o(core_do[0]),
    .do_b_o(core_do[1])
  );
  if (G_LATENCY > 1) begin : g_pipe
    localparam int PW = (G_LATENCY - 1) * G_WIDTH;
    logic [1:0][G_LATENCY-2:0][G_WIDTH-1:0] dat_q;
    // read stages beyond the core register; output is gated by valid so no reset needed
    always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) dat_q[p] <= PW'({dat_q[p], core_do[p]});
    end
    assign pipe_do = {dat_q[1][G_LATENCY-2], dat_q[0][G_LATENCY-2]};
  end else begin : g_nopipe
    assign pipe_do = core_do;
  end
  assign bus.memvld_a = vld_q[0][G_LATENCY-1];
  assign bus.memvld_b = vld_q[1][G_LATENCY-1];
  assign bus.memdo_a = bus.memvld_a ? pipe_do[0] : '0;
  assign bus.memdo_b = bus.memvld_b ? pipe_do[1] : '0;
  assign bus.coll_err = coll_q;
  assign bus.clrrdy = !busy;
endmodule
